// File: rtl/mult_shift_add.sv
// Sequential shift-and-add multiplier: one partial product per CALC cycle, sign handled
// by multiplying magnitudes and negating the final product.
module mult_shift_add #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     operand;
    logic [CW-1:0]        cnt;
    logic                 neg;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   sum;
    logic [WIDTH-1:0]     operand_next;
    logic                 last_iter;
    logic [2*WIDTH-1:0]   result;

    // The magnitude of the most negative value still fits in WIDTH bits when read unsigned.
    always_comb begin
        a_mag        = (signed_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
        b_mag        = (signed_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;
        sum          = operand[0] ? (acc + mcand) : acc;
        operand_next = operand >> 1;
        last_iter    = (cnt == LAST_ITER) || (EARLY_EXIT && (operand_next == '0));
        result       = neg ? (~sum + 1'b1) : sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            p       <= '0;
            mcand   <= '0;
            acc     <= '0;
            operand <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand   <= {{WIDTH{1'b0}}, a_mag};
                        operand <= b_mag;
                        neg     <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc     <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    acc     <= sum;
                    mcand   <= mcand << 1;
                    operand <= operand_next;
                    cnt     <= cnt + 1'b1;
                    if (last_iter) begin
                        p     <= result;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_shift_add.sv
// Directed and randomized checks of mult_shift_add at WIDTH 4, 8 and 16, both EARLY_EXIT settings.
module tb_mult_shift_add;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        start8, sm8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, busy8e, done8e;
    logic [15:0] p8, p8e;

    logic        start4, sm4;
    logic [3:0]  a4, b4;
    logic        busy4, done4, busy4e, done4e;
    logic [7:0]  p4, p4e;

    logic        start16, sm16;
    logic [15:0] a16, b16;
    logic        busy16, done16, busy16e, done16e;
    logic [31:0] p16, p16e;

    int checks = 0;
    int passed = 0;

    mult_shift_add #(.WIDTH(8), .EARLY_EXIT(1'b0)) u8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .p(p8));
    mult_shift_add #(.WIDTH(8), .EARLY_EXIT(1'b1)) u8e (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
        .busy(busy8e), .done(done8e), .p(p8e));
    mult_shift_add #(.WIDTH(4), .EARLY_EXIT(1'b0)) u4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .p(p4));
    mult_shift_add #(.WIDTH(4), .EARLY_EXIT(1'b1)) u4e (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4), .a(a4), .b(b4),
        .busy(busy4e), .done(done4e), .p(p4e));
    mult_shift_add #(.WIDTH(16), .EARLY_EXIT(1'b0)) u16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .p(p16));
    mult_shift_add #(.WIDTH(16), .EARLY_EXIT(1'b1)) u16e (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16), .a(a16), .b(b16),
        .busy(busy16e), .done(done16e), .p(p16e));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one WIDTH=8 operation to both instances and watch 20 cycles after acceptance.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic smv,
                        output logic [15:0] r0, output logic [15:0] r1,
                        output int l0, output int l1, output int bc, output int dc);
        a8 = av; b8 = bv; sm8 = smv; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        r0 = '0; r1 = '0; l0 = 0; l1 = 0; bc = 0; dc = 0;
        for (int c = 1; c <= 20; c++) begin
            if (busy8) bc++;
            if (done8) dc++;
            if (done8 && l0 == 0) begin l0 = c; r0 = p8; end
            if (done8e && l1 == 0) begin l1 = c; r1 = p8e; end
            tick;
        end
        $display("op w8 a=%h b=%h signed=%0d : p=%h lat=%0d | early p=%h lat=%0d",
                 av, bv, smv, r0, l0, r1, l1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        checks++;
        if ({busy8, done8, p8} !== 18'd0) $display("FAIL reset_w8 got busy=%b done=%b p=%h want 0 0 0000", busy8, done8, p8);
        else passed++;
        checks++;
        if ({busy8e, done8e, p8e} !== 18'd0) $display("FAIL reset_w8e got busy=%b done=%b p=%h want 0 0 0000", busy8e, done8e, p8e);
        else passed++;
        checks++;
        if ({busy16, done16, p16} !== 34'd0) $display("FAIL reset_w16 got busy=%b done=%b p=%h want 0 0 0", busy16, done16, p16);
        else passed++;
        rst = 1'b0;
        tick;
        $display("op reset released");
    endtask

    task automatic test_unsigned_max;
        logic [15:0] r0, r1;
        int l0, l1, bc, dc;
        run8(8'hFF, 8'hFF, 1'b0, r0, r1, l0, l1, bc, dc);
        checks++;
        if (r0 !== 16'hFE01) $display("FAIL umax_p got %h want fe01", r0); else passed++;
        checks++;
        if (l0 !== 9) $display("FAIL umax_latency got %0d want 9", l0); else passed++;
        checks++;
        if (bc !== 8) $display("FAIL umax_busy_cycles got %0d want 8", bc); else passed++;
        checks++;
        if (dc !== 1) $display("FAIL umax_done_cycles got %0d want 1", dc); else passed++;
        checks++;
        if (r1 !== 16'hFE01 || l1 !== 9) $display("FAIL umax_early got p=%h lat=%0d want fe01 9", r1, l1); else passed++;
    endtask

    task automatic test_signed;
        logic [15:0] r0, r1;
        int l0, l1, bc, dc;
        run8(8'hFD, 8'h05, 1'b1, r0, r1, l0, l1, bc, dc);
        checks++;
        if (r0 !== 16'hFFF1) $display("FAIL signed_m3x5 got %h want fff1", r0); else passed++;
        checks++;
        if (r1 !== 16'hFFF1 || l1 !== 4) $display("FAIL signed_m3x5_early got p=%h lat=%0d want fff1 4", r1, l1); else passed++;
        run8(8'h80, 8'h80, 1'b1, r0, r1, l0, l1, bc, dc);
        checks++;
        if (r0 !== 16'h4000) $display("FAIL signed_min_sq got %h want 4000", r0); else passed++;
        checks++;
        if (r1 !== 16'h4000 || l1 !== 9) $display("FAIL signed_min_sq_early got p=%h lat=%0d want 4000 9", r1, l1); else passed++;
    endtask

    task automatic test_early_exit;
        logic [15:0] r0, r1;
        int l0, l1, bc, dc;
        run8(8'd7, 8'd1, 1'b0, r0, r1, l0, l1, bc, dc);
        checks++;
        if (r1 !== 16'd7) $display("FAIL early_7x1_p got %h want 0007", r1); else passed++;
        checks++;
        if (l1 !== 2) $display("FAIL early_7x1_latency got %0d want 2", l1); else passed++;
        checks++;
        if (r0 !== 16'd7 || l0 !== 9) $display("FAIL full_7x1 got p=%h lat=%0d want 0007 9", r0, l0); else passed++;
        run8(8'd7, 8'd0, 1'b0, r0, r1, l0, l1, bc, dc);
        checks++;
        if (r1 !== 16'd0) $display("FAIL early_7x0_p got %h want 0000", r1); else passed++;
        checks++;
        if (l1 !== 2) $display("FAIL early_7x0_latency got %0d want 2", l1); else passed++;
    endtask

    task automatic test_start_ignored;
        int dc;
        logic [15:0] r0;
        dc = 0; r0 = '0;
        a8 = 8'd2; b8 = 8'd3; sm8 = 1'b0; start8 = 1'b1;
        tick;
        a8 = 8'd9; b8 = 8'd9;
        for (int c = 1; c <= 14; c++) begin
            if (done8) begin dc++; r0 = p8; end
            if (c == 3) start8 = 1'b0;
            tick;
        end
        $display("op w8 a=2 then 9 during busy : p=%h done_pulses=%0d", r0, dc);
        checks++;
        if (r0 !== 16'd6) $display("FAIL ignore_start_p got %h want 0006", r0); else passed++;
        checks++;
        if (dc !== 1) $display("FAIL ignore_start_pulses got %0d want 1", dc); else passed++;
    endtask

    task automatic test_back_to_back;
        int d0a, d0b, d1a, d1b;
        logic [15:0] r0;
        d0a = 0; d0b = 0; d1a = 0; d1b = 0; r0 = '0;
        a8 = 8'd3; b8 = 8'd5; sm8 = 1'b0; start8 = 1'b1;
        tick;
        for (int c = 1; c <= 25; c++) begin
            if (done8) begin
                r0 = p8;
                if (d0a == 0) d0a = c; else if (d0b == 0) d0b = c;
            end
            if (done8e) begin
                if (d1a == 0) d1a = c; else if (d1b == 0) d1b = c;
            end
            tick;
        end
        start8 = 1'b0;
        for (int c = 0; c < 25; c++) tick;
        $display("op w8 3x5 held start : p=%h done at %0d,%0d | early at %0d,%0d", r0, d0a, d0b, d1a, d1b);
        checks++;
        if (d0a !== 9 || d0b !== 19) $display("FAIL b2b_full got done at %0d,%0d want 9,19", d0a, d0b); else passed++;
        checks++;
        if (d1a !== 4 || d1b !== 9) $display("FAIL b2b_early got done at %0d,%0d want 4,9", d1a, d1b); else passed++;
        checks++;
        if (r0 !== 16'd15) $display("FAIL b2b_p got %h want 000f", r0); else passed++;
    endtask

    task automatic test_reset_mid_calc;
        int dc;
        logic [15:0] r0, r1;
        int l0, l1, bc, dc2;
        a8 = 8'd200; b8 = 8'd200; sm8 = 1'b0; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        tick;
        tick;
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 16'd0)
            $display("FAIL async_reset got busy=%b done=%b p=%h want 0 0 0000", busy8, done8, p8);
        else passed++;
        @(posedge clk);
        #3;
        rst = 1'b0;
        dc = 0;
        for (int c = 0; c < 15; c++) begin
            tick;
            if (done8 || busy8) dc++;
        end
        $display("op w8 reset mid-calc : activity_after_reset=%0d", dc);
        checks++;
        if (dc !== 0) $display("FAIL reset_abort got %0d active cycles want 0", dc); else passed++;
        run8(8'd4, 8'd4, 1'b0, r0, r1, l0, l1, bc, dc2);
        checks++;
        if (r0 !== 16'd16 || l0 !== 9) $display("FAIL after_reset_4x4 got p=%h lat=%0d want 0010 9", r0, l0); else passed++;
    endtask

    task automatic test_random_w4;
        longint ea, eb, prod;
        logic [7:0] ev, r0, r1;
        logic [3:0] mb;
        int hb, l0, l1, el1;
        for (int n = 0; n < 1000; n++) begin
            a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom);
            ea = sm4 ? longint'($signed(a4)) : longint'(a4);
            eb = sm4 ? longint'($signed(b4)) : longint'(b4);
            prod = ea * eb;
            ev = prod[7:0];
            mb = (sm4 && b4[3]) ? 4'(-b4) : b4;
            hb = 0;
            for (int i = 0; i < 4; i++) if (mb[i]) hb = i + 1;
            el1 = ((hb == 0) ? 1 : hb) + 1;
            start4 = 1'b1;
            tick;
            start4 = 1'b0;
            l0 = 0; l1 = 0; r0 = '0; r1 = '0;
            for (int c = 1; c <= 7; c++) begin
                if (done4 && l0 == 0) begin l0 = c; r0 = p4; end
                if (done4e && l1 == 0) begin l1 = c; r1 = p4e; end
                tick;
            end
            $display("op w4 a=%h b=%h signed=%0d : p=%h lat=%0d | early p=%h lat=%0d", a4, b4, sm4, r0, l0, r1, l1);
            checks++;
            if (r0 !== ev || l0 !== 5) $display("FAIL rand_w4 a=%h b=%h s=%0d got p=%h lat=%0d want %h 5", a4, b4, sm4, r0, l0, ev);
            else passed++;
            checks++;
            if (r1 !== ev || l1 !== el1) $display("FAIL rand_w4_early a=%h b=%h s=%0d got p=%h lat=%0d want %h %0d", a4, b4, sm4, r1, l1, ev, el1);
            else passed++;
        end
    endtask

    task automatic test_random_w16;
        longint ea, eb, prod;
        logic [31:0] ev, r0, r1;
        logic [15:0] mb;
        int hb, l0, l1, el1;
        for (int n = 0; n < 1000; n++) begin
            a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1'($urandom);
            if (n == 0) begin a16 = 16'h8000; b16 = 16'h8000; sm16 = 1'b1; end
            ea = sm16 ? longint'($signed(a16)) : longint'(a16);
            eb = sm16 ? longint'($signed(b16)) : longint'(b16);
            prod = ea * eb;
            ev = prod[31:0];
            mb = (sm16 && b16[15]) ? 16'(-b16) : b16;
            hb = 0;
            for (int i = 0; i < 16; i++) if (mb[i]) hb = i + 1;
            el1 = ((hb == 0) ? 1 : hb) + 1;
            start16 = 1'b1;
            tick;
            start16 = 1'b0;
            l0 = 0; l1 = 0; r0 = '0; r1 = '0;
            for (int c = 1; c <= 19; c++) begin
                if (done16 && l0 == 0) begin l0 = c; r0 = p16; end
                if (done16e && l1 == 0) begin l1 = c; r1 = p16e; end
                tick;
            end
            $display("op w16 a=%h b=%h signed=%0d : p=%h lat=%0d | early p=%h lat=%0d", a16, b16, sm16, r0, l0, r1, l1);
            checks++;
            if (r0 !== ev || l0 !== 17) $display("FAIL rand_w16 a=%h b=%h s=%0d got p=%h lat=%0d want %h 17", a16, b16, sm16, r0, l0, ev);
            else passed++;
            checks++;
            if (r1 !== ev || l1 !== el1) $display("FAIL rand_w16_early a=%h b=%h s=%0d got p=%h lat=%0d want %h %0d", a16, b16, sm16, r1, l1, ev, el1);
            else passed++;
        end
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
        start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
        test_reset;
        test_unsigned_max;
        test_signed;
        test_early_exit;
        test_start_ignored;
        test_back_to_back;
        test_reset_mid_calc;
        test_random_w4;
        test_random_w16;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
